// File: rtl/cacheline_adapter_if.sv
// Cache-side and memory-side handshake bundle for cacheline_adapter.
// The adapter connects through the slave modport; the cache/memory environment uses master.
interface cacheline_adapter_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [31:0]        address_i;
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [31:0]        address_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport master (
    output address_i, line_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, burst_o, read_o, write_o
  );

  modport slave (
    input  address_i, line_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, address_o, burst_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits cache line fetches/writebacks into num_beats memory bursts.
// Optional line counters are enabled by defining CACHELINE_ADAPTER_PERF_CNT_EN.
module cacheline_adapter #(
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int s_offset  = 5,
  parameter int num_beats = s_line / s_burst
) (
  input  logic              clk,
  input  logic              rst,
  cacheline_adapter_if.slave bus
`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
  ,
  output logic [31:0]       rd_lines_o,
  output logic [31:0]       wr_lines_o
`endif
);

  localparam int cnt_w = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state;
  logic [cnt_w-1:0]   beat;
  logic [cnt_w-1:0]   next_beat;
  logic               last;
  logic [s_line-1:0]  wr_line;
  logic [31:0]        line_addr;
  logic               addr_unused;

  assign next_beat   = beat + cnt_w'(1);
  assign last        = (beat == last_beat);
  assign line_addr   = {bus.address_i[31:s_offset], {s_offset{1'b0}}};
  assign addr_unused = ^bus.address_i[s_offset-1:0];

  // Writeback wins over fetch when both requests arrive together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      beat          <= '0;
      wr_line       <= '0;
      bus.resp_o    <= 1'b0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.address_o <= '0;
      bus.burst_o   <= '0;
      bus.line_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_o <= 1'b0;
          if (bus.write_i) begin
            state         <= WRITE;
            beat          <= '0;
            wr_line       <= bus.line_i;
            bus.address_o <= line_addr;
            bus.burst_o   <= bus.line_i[s_burst-1:0];
            bus.write_o   <= 1'b1;
          end else if (bus.read_i) begin
            state         <= READ;
            beat          <= '0;
            bus.address_o <= line_addr;
            bus.read_o    <= 1'b1;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            bus.line_o[int'(beat)*s_burst +: s_burst] <= bus.burst_i;
            beat <= next_beat;
            if (last) begin
              state      <= DONE;
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            beat        <= next_beat;
            bus.burst_o <= wr_line[int'(next_beat)*s_burst +: s_burst];
            if (last) begin
              state       <= DONE;
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
            end
          end
        end
        DONE: begin
          bus.resp_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
  // Counters bump on the final beat, i.e. the cycle the FSM enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_lines_o <= '0;
      wr_lines_o <= '0;
    end else if (bus.resp_i && last) begin
      if (state == READ && rd_lines_o != '1)
        rd_lines_o <= rd_lines_o + 32'd1;
      if (state == WRITE && wr_lines_o != '1)
        wr_lines_o <= wr_lines_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter; outputs sampled 1ns after rising edges.
// Optional counter checks follow CACHELINE_ADAPTER_PERF_CNT_EN.
module tb_cacheline_adapter;
  localparam int s_line  = 256;
  localparam int s_burst = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cacheline_adapter_if #(.s_line(s_line), .s_burst(s_burst)) bus();

`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
  logic [31:0] rd_lines;
  logic [31:0] wr_lines;
`endif

  cacheline_adapter #(.s_line(s_line), .s_burst(s_burst), .s_offset(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
    ,
    .rd_lines_o(rd_lines),
    .wr_lines_o(wr_lines)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.address_i = '0; bus.line_i = '0; bus.read_i = 0; bus.write_i = 0;
    bus.burst_i = '0; bus.resp_i = 0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000 || bus.address_o !== 32'h0 ||
        bus.burst_o !== 64'h0 || bus.line_o !== 256'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got resp/rd/wr=%b%b%b addr=%h burst=%h, want all zero",
               bus.resp_o, bus.read_o, bus.write_o, bus.address_o, bus.burst_o);
    end
    tick; tick;
    rst = 1'b1;
    bus.resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL idle_resp_ignored: got resp/rd/wr=%b%b%b, want 000",
                 bus.resp_o, bus.read_o, bus.write_o);
      end
    end
    bus.resp_i = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [255:0] wline;
    logic [255:0] rline;
    wline = {64'h9999_0003_9999_0003, 64'h9999_0002_9999_0002,
             64'h9999_0001_9999_0001, 64'h9999_0000_9999_0000};
    rline = {64'h0123_4567_89AB_CDE3, 64'h0123_4567_89AB_CDE2,
             64'h0123_4567_89AB_CDE1, 64'h0123_4567_89AB_CDE0};
    bus.line_i = wline; bus.address_i = 32'h0000_ABCD; bus.write_i = 1; bus.resp_i = 1;
    tick; tick; tick;
    checks++;
    if (bus.write_o !== 1'b1 || bus.burst_o !== 64'h9999_0002_9999_0002) begin
      errors++;
      $display("[TB] FAIL abort_beat2: got write_o=%b burst_o=%h, want 1 9999000299990002",
               bus.write_o, bus.burst_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000 || bus.address_o !== 32'h0 ||
        bus.burst_o !== 64'h0 || bus.line_o !== 256'h0) begin
      errors++;
      $display("[TB] FAIL abort_async_clear: got resp/rd/wr=%b%b%b addr=%h burst=%h, want zeros",
               bus.resp_o, bus.read_o, bus.write_o, bus.address_o, bus.burst_o);
    end
    bus.write_i = 0; bus.resp_i = 0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({bus.resp_o, bus.read_o, bus.write_o} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL abort_no_resp: got resp/rd/wr=%b%b%b, want 000",
                 bus.resp_o, bus.read_o, bus.write_o);
      end
    end
    bus.address_i = 32'h0000_0047; bus.read_i = 1; bus.resp_i = 1;
    tick;
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = rline[k*64 +: 64];
      checks++;
      if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0 || bus.address_o !== 32'h0000_0040) begin
        errors++;
        $display("[TB] FAIL post_abort_read beat %0d: got read_o=%b resp_o=%b addr=%h, want 1 0 00000040",
                 k, bus.read_o, bus.resp_o, bus.address_o);
      end
      tick;
    end
    checks++;
    if (bus.resp_o !== 1'b1 || bus.line_o !== rline) begin
      errors++;
      $display("[TB] FAIL post_abort_done: got resp_o=%b line_o=%h, want 1 %h",
               bus.resp_o, bus.line_o, rline);
    end
    bus.read_i = 0; bus.resp_i = 0;
    tick;
  endtask

  task automatic test_read;
    logic [255:0] exp;
    exp = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    bus.address_i = 32'h1234_5678; bus.read_i = 1; bus.resp_i = 1; bus.burst_i = exp[63:0];
    tick;
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = exp[k*64 +: 64];
      checks++;
      if (bus.read_o !== 1'b1 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0 ||
          bus.address_o !== 32'h1234_5660) begin
        errors++;
        $display("[TB] FAIL read_beat %0d: got rd/wr/resp=%b%b%b addr=%h, want 100 12345660",
                 k, bus.read_o, bus.write_o, bus.resp_o, bus.address_o);
      end
      if (k == 1) bus.address_i = 32'hDEAD_BEEF;
      tick;
    end
    checks++;
    if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0 || bus.line_o !== exp ||
        bus.address_o !== 32'h1234_5660) begin
      errors++;
      $display("[TB] FAIL read_done: got resp=%b rd=%b addr=%h line=%h, want 1 0 12345660 %h",
               bus.resp_o, bus.read_o, bus.address_o, bus.line_o, exp);
    end
    bus.read_i = 0; bus.resp_i = 0;
    tick;
    checks++;
    if (bus.resp_o !== 1'b0 || bus.line_o !== exp) begin
      errors++;
      $display("[TB] FAIL read_after: got resp_o=%b line held=%b, want 0 1",
               bus.resp_o, bus.line_o === exp);
    end
  endtask

  task automatic test_write;
    logic [255:0] wline;
    wline = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
             64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    bus.line_i = wline; bus.address_i = 32'h8000_0020; bus.write_i = 1; bus.resp_i = 1;
    tick;
    bus.line_i = '1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.resp_o !== 1'b0 ||
          bus.burst_o !== wline[k*64 +: 64] || bus.address_o !== 32'h8000_0020) begin
        errors++;
        $display("[TB] FAIL write_beat %0d: got wr/rd/resp=%b%b%b burst=%h, want 100 %h",
                 k, bus.write_o, bus.read_o, bus.resp_o, bus.burst_o, wline[k*64 +: 64]);
      end
      tick;
    end
    checks++;
    if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_done: got resp_o=%b write_o=%b, want 1 0", bus.resp_o, bus.write_o);
    end
    bus.write_i = 0; bus.resp_i = 0;
    tick;
    checks++;
    if (bus.resp_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_single_resp: got resp_o=%b, want 0", bus.resp_o);
    end
  endtask

  task automatic test_stall;
    logic [255:0] exp;
    exp = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
           64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
    bus.address_i = 32'hCAFE_F01F; bus.read_i = 1; bus.resp_i = 1; bus.burst_i = exp[63:0];
    tick;
    bus.burst_i = exp[63:0];
    tick;
    bus.burst_i = exp[127:64];
    tick;
    bus.resp_i = 0; bus.burst_i = '1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0 || bus.address_o !== 32'hCAFE_F000 ||
          bus.line_o[191:128] !== 64'h3333_3333_3333_3333 || bus.line_o[127:0] !== exp[127:0]) begin
        errors++;
        $display("[TB] FAIL stall_cycle %0d: got rd=%b resp=%b addr=%h line=%h",
                 i, bus.read_o, bus.resp_o, bus.address_o, bus.line_o);
      end
      tick;
    end
    bus.resp_i = 1; bus.burst_i = exp[191:128];
    checks++;
    if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_resume: got resp_o=%b read_o=%b, want 0 1", bus.resp_o, bus.read_o);
    end
    tick;
    bus.burst_i = exp[255:192];
    tick;
    checks++;
    if (bus.resp_o !== 1'b1 || bus.line_o !== exp) begin
      errors++;
      $display("[TB] FAIL stall_done: got resp_o=%b line_o=%h, want 1 %h", bus.resp_o, bus.line_o, exp);
    end
    bus.read_i = 0; bus.resp_i = 0;
    tick;
  endtask

  task automatic test_both;
    logic [255:0] wline;
    wline = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
             64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    bus.line_i = wline; bus.address_i = 32'h0000_1000;
    bus.read_i = 1; bus.write_i = 1; bus.resp_i = 1;
    tick;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.burst_o !== wline[k*64 +: 64]) begin
        errors++;
        $display("[TB] FAIL both_beat %0d: got wr=%b rd=%b burst=%h, want 1 0 %h",
                 k, bus.write_o, bus.read_o, bus.burst_o, wline[k*64 +: 64]);
      end
      tick;
    end
    checks++;
    if (bus.resp_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_done: got resp_o=%b, want 1", bus.resp_o);
    end
    bus.read_i = 0; bus.write_i = 0; bus.resp_i = 0;
    tick;
  endtask

  task automatic test_perf;
`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
    checks++;
    if (rd_lines !== 32'd3 || wr_lines !== 32'd2) begin
      errors++;
      $display("[TB] FAIL perf_counts: got rd=%0d wr=%0d, want 3 2", rd_lines, wr_lines);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_reset_abort;
    test_read;
    test_write;
    test_stall;
    test_both;
    test_perf;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
